// File: rtl/data_path.sv
// 16x16 register file + ALU; flags and result are combinational, register/carry update 1 cycle.
// No backpressure: the controlling FSM presents one operation per cycle.
module data_path (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wEnable,
  input  logic [15:0] Imm_in,
  input  logic [7:0]  opcode,
  input  logic [3:0]  Rdest_select,
  input  logic [3:0]  Rsrc_select,
  input  logic        Imm_select,
  output logic [4:0]  Flags_out
);

  typedef enum logic [3:0] {
    OP_NONE, OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDC,
    OP_SUB, OP_CMP, OP_MOV, OP_LSH, OP_ARSH, OP_RSH
  } op_t;

  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
  logic [15:0] rf [16];
  logic        creg;
  op_t         op;
  logic [15:0] a, b, res;
  logic [16:0] sum17, diff17;
  logic [15:0] arsh;
  logic        c, z, f, l, n;

  assign rf = '{r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15};
  assign a  = rf[Rdest_select];
  assign b  = Imm_select ? Imm_in : rf[Rsrc_select];

  // Register form, shift group, or immediate form keyed by the high nibble
  always_comb begin
    op = OP_NONE;
    if (opcode[7:4] == 4'h0) begin
      case (opcode[3:0])
        4'h0: op = OP_NOP;
        4'h1: op = OP_AND;
        4'h2: op = OP_OR;
        4'h3: op = OP_XOR;
        4'h4: op = OP_NOT;
        4'h5, 4'h6: op = OP_ADD;
        4'h7: op = OP_ADDC;
        4'h9: op = OP_SUB;
        4'hB: op = OP_CMP;
        4'hD: op = OP_MOV;
        default: op = OP_NONE;
      endcase
    end else if (opcode[7:4] == 4'h8) begin
      case (opcode[3:0])
        4'h0, 4'h1, 4'h4: op = OP_LSH;
        4'h2, 4'h3, 4'h6: op = OP_ARSH;
        4'h8, 4'h9, 4'hA, 4'hB: op = OP_RSH;
        default: op = OP_NONE;
      endcase
    end else begin
      case (opcode[7:4])
        4'h1: op = OP_AND;
        4'h2: op = OP_OR;
        4'h3: op = OP_XOR;
        4'h5, 4'h6: op = OP_ADD;
        4'h7: op = OP_ADDC;
        4'h9: op = OP_SUB;
        4'hB: op = OP_CMP;
        4'hD: op = OP_MOV;
        default: op = OP_NONE;
      endcase
    end
  end

  assign sum17  = {1'b0, a} + {1'b0, b} + {16'd0, (op == OP_ADDC) & creg};
  assign diff17 = {1'b0, a} - {1'b0, b};
  assign arsh   = 16'($signed(a) >>> b[3:0]);

  always_comb begin
    res = 16'h0000;
    c = 1'b0; z = 1'b0; f = 1'b0; l = 1'b0; n = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_ADD, OP_ADDC: begin
        res = sum17[15:0];
        c   = sum17[16];
        f   = (a[15] == b[15]) && (res[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        res = diff17[15:0];
        c   = diff17[16];
        f   = (a[15] != b[15]) && (res[15] != a[15]);
      end
      OP_MOV:  res = b;
      OP_LSH:  res = a << b[3:0];
      OP_ARSH: res = arsh;
      OP_RSH:  res = a >> b[3:0];
      default: res = 16'h0000;
    endcase
    if (op != OP_NONE && op != OP_NOP) begin
      z = (res == 16'h0000);
      n = res[15];
    end
    // Compare reports ordering rather than arithmetic carry/overflow
    if (op == OP_CMP) begin
      c = 1'b0;
      f = 1'b0;
      z = (a == b);
      l = (a < b);
      n = ($signed(a) < $signed(b));
    end
  end

  assign Flags_out = {n, l, f, z, c};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0; r5 <= '0; r6 <= '0; r7 <= '0;
      r8 <= '0; r9 <= '0; r10 <= '0; r11 <= '0; r12 <= '0; r13 <= '0; r14 <= '0; r15 <= '0;
      creg <= 1'b0;
    end else begin
      if (wEnable[0])  r0  <= res;
      if (wEnable[1])  r1  <= res;
      if (wEnable[2])  r2  <= res;
      if (wEnable[3])  r3  <= res;
      if (wEnable[4])  r4  <= res;
      if (wEnable[5])  r5  <= res;
      if (wEnable[6])  r6  <= res;
      if (wEnable[7])  r7  <= res;
      if (wEnable[8])  r8  <= res;
      if (wEnable[9])  r9  <= res;
      if (wEnable[10]) r10 <= res;
      if (wEnable[11]) r11 <= res;
      if (wEnable[12]) r12 <= res;
      if (wEnable[13]) r13 <= res;
      if (wEnable[14]) r14 <= res;
      if (wEnable[15]) r15 <= res;
      if (op == OP_ADD || op == OP_ADDC || op == OP_SUB) creg <= c;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed vectors for data_path; expected flags are queued by the driver and checked by a monitor.
module tb_data_path;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] wEnable = '0;
  logic [15:0] Imm_in = '0;
  logic [7:0]  opcode = '0;
  logic [3:0]  Rdest_select = '0;
  logic [3:0]  Rsrc_select = '0;
  logic        Imm_select = 1'b0;
  logic [4:0]  Flags_out;

  logic        vec_vld = 1'b0;
  logic [4:0]  exp_q [$];
  string       name_q [$];
  int          checks = 0;
  int          failures = 0;

  data_path dut (
    .clk(clk), .reset(reset), .wEnable(wEnable), .Imm_in(Imm_in), .opcode(opcode),
    .Rdest_select(Rdest_select), .Rsrc_select(Rsrc_select), .Imm_select(Imm_select),
    .Flags_out(Flags_out)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] FZ = 5'b00010;

  task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic isel, input logic [15:0] imm, input logic [15:0] we,
                       input logic [4:0] ef, input string nm);
    @(posedge clk);
    #1;
    opcode = op; Rdest_select = rd; Rsrc_select = rs;
    Imm_select = isel; Imm_in = imm; wEnable = we;
    vec_vld = 1'b1;
    exp_q.push_back(ef);
    name_q.push_back(nm);
  endtask

  // Register content check: compare-immediate against the expected value must report Z only
  task automatic chk(input logic [3:0] rd, input logic [15:0] val, input string nm);
    issue(8'hB0, rd, 4'h0, 1'b1, val, 16'h0000, FZ, nm);
  endtask

  always @(negedge clk) begin
    if (vec_vld) begin
      logic [4:0] e;
      string nm;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL monitor: output presented with flags=%b but no expectation queued", Flags_out);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (Flags_out !== e) begin
          failures++;
          $display("FAIL %s: flags=%b expected %b", nm, Flags_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    issue(8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 16'hFFFF, 5'b00000, "nop_in_reset");
    chk(4'h0, 16'h0000, "r0_in_reset");
    reset = 1'b1;
    chk(4'h7, 16'h0000, "r7_after_reset");

    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0001, 5'b00000, "movi_r0");
    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'h0001, 16'h0002, 5'b00000, "movi_r1");
    issue(8'h05, 4'h0, 4'h1, 1'b0, 16'h0000, 16'h0004, 5'b10100, "add_ovf");
    issue(8'h09, 4'h1, 4'h0, 1'b0, 16'h0000, 16'h0008, 5'b10001, "sub_borrow");
    issue(8'h90, 4'h0, 4'h0, 1'b1, 16'h7FFF, 16'h0010, FZ,       "subi_zero");
    issue(8'h0B, 4'h0, 4'h1, 1'b0, 16'h0000, 16'h0000, 5'b00000, "cmp_gt");
    issue(8'hB0, 4'h4, 4'h0, 1'b1, 16'h0000, 16'h0000, FZ,       "cmpi_eq");
    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'hFFFF, 16'h0040, 5'b10000, "movi_r6");
    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'h0001, 16'h0080, 5'b00000, "movi_r7");
    issue(8'h06, 4'h6, 4'h7, 1'b0, 16'h0000, 16'h0100, 5'b00011, "addu_carry");
    issue(8'h07, 4'h7, 4'h7, 1'b0, 16'h0000, 16'h2000, 5'b00000, "addc_next");
    issue(8'h01, 4'h6, 4'h7, 1'b0, 16'h0000, 16'h0200, 5'b00000, "and");
    issue(8'h02, 4'h0, 4'h1, 1'b0, 16'h0000, 16'h0400, 5'b00000, "or");
    issue(8'h03, 4'h7, 4'h7, 1'b0, 16'h0000, 16'h0800, FZ,       "xor_zero");
    issue(8'h04, 4'h4, 4'h0, 1'b0, 16'h0000, 16'h1000, 5'b10000, "not");
    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'h1111, 16'h8000, 5'b00000, "movi_r15");

    chk(4'h0, 16'h7FFF, "r0");
    chk(4'h1, 16'h0001, "r1");
    chk(4'h2, 16'h8000, "r2");
    chk(4'h3, 16'h8002, "r3");
    chk(4'h4, 16'h0000, "r4");
    chk(4'h5, 16'h0000, "r5_untouched_by_cmp");
    chk(4'h8, 16'h0000, "r8");
    chk(4'h9, 16'h0001, "r9");
    chk(4'hA, 16'h7FFF, "r10");
    chk(4'hB, 16'h0000, "r11");
    chk(4'hC, 16'hFFFF, "r12");
    chk(4'hD, 16'h0003, "r13_addc");
    chk(4'hF, 16'h1111, "r15");

    issue(8'h80, 4'h1, 4'h0, 1'b1, 16'h0004, 16'h4000, 5'b00000, "lshi");
    chk(4'hE, 16'h0010, "r14_lshi");
    issue(8'h86, 4'h3, 4'h7, 1'b0, 16'h0000, 16'h4000, 5'b10000, "arsh");
    chk(4'hE, 16'hC001, "r14_arsh");
    issue(8'h8A, 4'h3, 4'h0, 1'b1, 16'h0001, 16'h4000, 5'b00000, "rshi");
    chk(4'hE, 16'h4001, "r14_rshi");
    issue(8'h84, 4'h1, 4'h0, 1'b1, 16'h0013, 16'h4000, 5'b00000, "lsh_low_nibble");
    chk(4'hE, 16'h0008, "r14_lsh");

    issue(8'h0B, 4'h6, 4'h7, 1'b0, 16'h0000, 16'h0000, 5'b10000, "cmp_signed_less");
    issue(8'h0B, 4'h7, 4'h6, 1'b0, 16'h0000, 16'h0000, 5'b01000, "cmp_unsigned_less");

    issue(8'h09, 4'h1, 4'h0, 1'b0, 16'h0000, 16'h0000, 5'b10001, "sub_sets_creg");
    issue(8'h03, 4'h7, 4'h7, 1'b0, 16'h0000, 16'h0000, FZ,       "xor_holds_creg");
    issue(8'h70, 4'h1, 4'h0, 1'b1, 16'h0000, 16'h4000, 5'b00000, "addci_creg");
    chk(4'hE, 16'h0002, "r14_addci");
    issue(8'h50, 4'h6, 4'h0, 1'b1, 16'h0001, 16'h0000, 5'b00011, "addi_wrap");

    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'h00AA, 16'h0060, 5'b00000, "movi_multi");
    chk(4'h5, 16'h00AA, "r5_multi");
    chk(4'h6, 16'h00AA, "r6_multi");
    issue(8'h0E, 4'h0, 4'h1, 1'b0, 16'h0000, 16'h4000, 5'b00000, "invalid_0e");
    chk(4'hE, 16'h0000, "r14_invalid");
    issue(8'h40, 4'h0, 4'h0, 1'b1, 16'h0005, 16'h0000, 5'b00000, "invalid_4x");

    issue(8'h50, 4'hC, 4'h0, 1'b1, 16'h0001, 16'h0000, 5'b00011, "addi_set_creg");
    issue(8'hD0, 4'h0, 4'h0, 1'b1, 16'h1234, 16'h0001, 5'b00000, "movi_during_reset");
    #2 reset = 1'b0;
    chk(4'h0, 16'h0000, "r0_write_suppressed");
    reset = 1'b1;
    issue(8'h70, 4'h1, 4'h0, 1'b1, 16'h0000, 16'h0000, FZ, "addci_creg_cleared");
    chk(4'hF, 16'h0000, "r15_cleared");
    chk(4'hC, 16'h0000, "r12_cleared");

    @(posedge clk);
    #1;
    vec_vld = 1'b0;
    wEnable = '0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
